// File: rtl/pipelined_alu.sv
// pipelined_alu: registered ALU with a valid/ready handshake on both sides.
// Single-cycle ops complete with latency 1. MUL, when enabled, runs as an
// iterative shift-add multiplier for WIDTH cycles. The output register holds
// its result and flags until the consumer takes them.
module pipelined_alu #(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_illegal
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   result_q;
  logic               zero_q;
  logic               neg_q;
  logic               carry_q;
  logic               ovf_q;
  logic               illegal_q;

  // Iterative multiplier state: the multiplicand shifts left and the
  // multiplier shifts right so each step only ever inspects bit 0.
  logic [SW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] prod_d;

  // Single-cycle datapath results for the op currently offered.
  logic [WIDTH-1:0]   res_d;
  logic               carry_d;
  logic               ovf_d;
  logic               illegal_d;

  logic               accept;
  logic               is_mul;
  logic [SW-1:0]      shamt;
  logic [WIDTH:0]     sum_w;
  logic [WIDTH:0]     diff_w;
  logic [WIDTH:0]     shl_w;
  logic [WIDTH:0]     shr_w;
  logic signed [WIDTH:0] sra_w;

  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = MUL_EN && (in_op == OP_MUL);

  // Shifts carry one guard bit so the last bit shifted out lands in it;
  // a zero shift leaves the guard bit clear.
  assign shamt  = in_b[SW-1:0];
  assign sum_w  = {1'b0, in_a} + {1'b0, in_b};
  assign diff_w = {1'b0, in_a} - {1'b0, in_b};
  assign shl_w  = {1'b0, in_a} << shamt;
  assign shr_w  = {in_a, 1'b0} >> shamt;
  assign sra_w  = $signed({in_a, 1'b0}) >>> shamt;

  assign prod_d = acc_q + (mplier_q[0] ? mcand_q : '0);

  assign out_valid   = (state_q == ST_DONE);
  assign out_result  = result_q;
  assign out_zero    = zero_q;
  assign out_neg     = neg_q;
  assign out_carry   = carry_q;
  assign out_ovf     = ovf_q;
  assign out_illegal = illegal_q;

  // Single-cycle op decode; MUL and undefined opcodes fall to the illegal arm.
  always_comb begin
    res_d     = '0;
    carry_d   = 1'b0;
    ovf_d     = 1'b0;
    illegal_d = 1'b0;
    case (in_op)
      OP_ADD: begin
        res_d   = sum_w[WIDTH-1:0];
        carry_d = sum_w[WIDTH];
        ovf_d   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum_w[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SUB: begin
        res_d   = diff_w[WIDTH-1:0];
        carry_d = diff_w[WIDTH];
        ovf_d   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (diff_w[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_AND: res_d = in_a & in_b;
      OP_OR:  res_d = in_a | in_b;
      OP_XOR: res_d = in_a ^ in_b;
      OP_SHL: begin
        res_d   = shl_w[WIDTH-1:0];
        carry_d = shl_w[WIDTH];
      end
      OP_SHR: begin
        res_d   = shr_w[WIDTH:1];
        carry_d = shr_w[0];
      end
      OP_SRA: begin
        res_d   = sra_w[WIDTH:1];
        carry_d = sra_w[0];
      end
      OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      OP_SLTU: res_d = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
      default: illegal_d = 1'b1;
    endcase
  end

  // Control FSM with registered result/flags and the multiplier iteration.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      neg_q     <= 1'b0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
    end else begin
      case (state_q)
        ST_BUSY: begin
          acc_q    <= prod_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == SW'(WIDTH - 1)) begin
            state_q   <= ST_DONE;
            result_q  <= prod_d[WIDTH-1:0];
            zero_q    <= (prod_d[WIDTH-1:0] == '0);
            neg_q     <= prod_d[WIDTH-1];
            carry_q   <= |prod_d[2*WIDTH-1:WIDTH];
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
          end
        end
        default: begin
          if (accept) begin
            if (is_mul) begin
              state_q  <= ST_BUSY;
              cnt_q    <= '0;
              acc_q    <= '0;
              mcand_q  <= {{WIDTH{1'b0}}, in_a};
              mplier_q <= in_b;
            end else begin
              state_q   <= ST_DONE;
              result_q  <= res_d;
              zero_q    <= (res_d == '0);
              neg_q     <= res_d[WIDTH-1];
              carry_q   <= carry_d;
              ovf_q     <= ovf_d;
              illegal_q <= illegal_d;
            end
          end else if ((state_q == ST_DONE) && out_ready) begin
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipelined_alu.sv
// Self-checking bench for pipelined_alu: directed steps with a scoreboard of
// expected results, plus a MUL_EN=0 instance for the illegal-MUL case.
module tb_pipelined_alu;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_a, in_b, out_result;
  logic [3:0] in_op;
  logic       out_zero, out_neg, out_carry, out_ovf, out_illegal;

  logic       n_in_valid, n_in_ready, n_out_valid, n_out_ready;
  logic [7:0] n_in_a, n_in_b, n_out_result;
  logic [3:0] n_in_op;
  logic       n_out_zero, n_out_neg, n_out_carry, n_out_ovf, n_out_illegal;

  pipelined_alu #(.WIDTH(8), .MUL_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_neg(out_neg),
    .out_carry(out_carry), .out_ovf(out_ovf), .out_illegal(out_illegal)
  );

  pipelined_alu #(.WIDTH(8), .MUL_EN(1'b0)) u_dut_nomul (
    .clk(clk), .rst(rst),
    .in_valid(n_in_valid), .in_ready(n_in_ready),
    .in_a(n_in_a), .in_b(n_in_b), .in_op(n_in_op),
    .out_valid(n_out_valid), .out_ready(n_out_ready),
    .out_result(n_out_result), .out_zero(n_out_zero), .out_neg(n_out_neg),
    .out_carry(n_out_carry), .out_ovf(n_out_ovf), .out_illegal(n_out_illegal)
  );

  typedef struct {
    string      tag;
    logic [7:0] r;
    logic       z, n, c, v, ill;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   passed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input string tag, input logic [7:0] r,
                              input logic c, input logic v, input logic ill);
    exp_t e;
    e.tag = tag;
    e.r   = r;
    e.z   = (r == 8'h00);
    e.n   = r[7];
    e.c   = c;
    e.v   = v;
    e.ill = ill;
    return e;
  endfunction

  // Scoreboard: every completed output handshake is matched to the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      chk("sb_pending", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        $display("txn %s: result=0x%02h z=%b n=%b c=%b v=%b ill=%b", e.tag, out_result,
                 out_zero, out_neg, out_carry, out_ovf, out_illegal);
        chk(e.tag, {out_result, out_zero, out_neg, out_carry, out_ovf, out_illegal},
            {e.r, e.z, e.n, e.c, e.v, e.ill});
      end
    end
  end

  // Offer one op; the caller is 1 time unit after a rising edge.
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input exp_t e);
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    sb_q.push_back(e);
    @(negedge clk);
    chk({e.tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // MUL with changing inputs during BUSY and an exact-latency check.
  task automatic mul_run(input logic [7:0] a, input logic [7:0] b, input exp_t e);
    send(OP_MUL, a, b, e);
    in_valid = 1'b1;
    in_op    = OP_ADD;
    in_a     = 8'($urandom);
    in_b     = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("%s_busy%0d", e.tag, i), {in_ready, out_valid}, 2'b00);
      if (i == 7) in_valid = 1'b0;
    end
    @(negedge clk);
    chk({e.tag, "_latency"}, 64'(out_valid), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_op = '0;
    n_in_valid = 1'b0; n_out_ready = 1'b1;
    n_in_a = '0; n_in_b = '0; n_in_op = '0;

    @(posedge clk);
    @(negedge clk);
    chk("reset_state", {out_valid, in_ready, out_result, out_zero, out_neg, out_carry, out_ovf, out_illegal},
        {1'b0, 1'b1, 8'h00, 5'b00000});
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 1. ADD wrap-around
    send(OP_ADD, 8'hFF, 8'h01, mk("add_ff_01", 8'h00, 1'b1, 1'b0, 1'b0));
    @(negedge clk);
    chk("add_latency", 64'(out_valid), 64'd1);
    @(posedge clk); #1;

    // 2. SUB / SLT / SLTU back to back
    send(OP_SUB,  8'h80, 8'h01, mk("sub_80_01",  8'h7F, 1'b0, 1'b1, 1'b0));
    send(OP_SLT,  8'h80, 8'h01, mk("slt_80_01",  8'h01, 1'b0, 1'b0, 1'b0));
    send(OP_SLTU, 8'h80, 8'h01, mk("sltu_80_01", 8'h00, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    chk("b2b_latency", 64'(out_valid), 64'd1);
    @(posedge clk); #1;

    // 3. MUL
    mul_run(8'h10, 8'h11, mk("mul_10_11", 8'h10, 1'b1, 1'b0, 1'b0));
    mul_run(8'h0F, 8'h03, mk("mul_0f_03", 8'h2D, 1'b0, 1'b0, 1'b0));

    // 4. Back-pressure then simultaneous release and new accept
    out_ready = 1'b0;
    send(OP_ADD, 8'h7F, 8'h01, mk("bp_add_7f_01", 8'h80, 1'b0, 1'b1, 1'b0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d", i),
          {out_valid, in_ready, out_result, out_zero, out_neg, out_carry, out_ovf, out_illegal},
          {1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(OP_XOR, 8'hAA, 8'hFF, mk("xor_aa_ff", 8'h55, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    chk("bp_no_bubble", {out_valid, out_result}, {1'b1, 8'h55});
    @(posedge clk); #1;

    // 5. Shifts, logic ops, illegal opcode
    send(OP_SRA, 8'h81, 8'h01, mk("sra_81_1", 8'hC0, 1'b1, 1'b0, 1'b0));
    send(OP_SHL, 8'h81, 8'h00, mk("shl_81_0", 8'h81, 1'b0, 1'b0, 1'b0));
    send(OP_SHL, 8'h81, 8'h01, mk("shl_81_1", 8'h02, 1'b1, 1'b0, 1'b0));
    send(OP_SHR, 8'h81, 8'h07, mk("shr_81_7", 8'h01, 1'b0, 1'b0, 1'b0));
    send(OP_AND, 8'hF0, 8'h3C, mk("and_f0_3c", 8'h30, 1'b0, 1'b0, 1'b0));
    send(OP_OR,  8'h0F, 8'h80, mk("or_0f_80", 8'h8F, 1'b0, 1'b0, 1'b0));
    send(4'hF,   8'h12, 8'h34, mk("illegal_f", 8'h00, 1'b0, 1'b0, 1'b1));
    @(negedge clk);
    chk("illegal_latency", 64'(out_valid), 64'd1);
    @(posedge clk); #1;

    // MUL_EN=0: op 10 is illegal with latency 1
    n_in_op = OP_MUL; n_in_a = 8'h03; n_in_b = 8'h05; n_in_valid = 1'b1;
    @(negedge clk);
    chk("nomul_in_ready", 64'(n_in_ready), 64'd1);
    @(posedge clk); #1;
    n_in_valid = 1'b0;
    @(negedge clk);
    $display("txn nomul_op10: result=0x%02h z=%b n=%b c=%b v=%b ill=%b", n_out_result,
             n_out_zero, n_out_neg, n_out_carry, n_out_ovf, n_out_illegal);
    chk("nomul_op10", {n_out_valid, n_out_result, n_out_zero, n_out_neg, n_out_carry, n_out_ovf, n_out_illegal},
        {1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
    @(posedge clk); #1;

    // 6. Reset in the middle of a MUL
    send(OP_MUL, 8'h10, 8'h11, mk("mul_abandoned", 8'h10, 1'b1, 1'b0, 1'b0));
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    @(negedge clk);
    chk("rst_mid_mul", {out_valid, in_ready, out_result, out_zero, out_neg, out_carry, out_ovf, out_illegal},
        {1'b0, 1'b1, 8'h00, 5'b00000});
    @(posedge clk); #1;
    send(OP_ADD, 8'h02, 8'h03, mk("add_after_rst", 8'h05, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    chk("add_after_rst_latency", 64'(out_valid), 64'd1);
    @(posedge clk); #1;

    @(negedge clk);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pipelined_alu.md
Name: pipelined_alu

Overview:
Parametrised, handshaked ALU that generalises the combinational ALU to a registered datapath with a valid/ready interface. It adds a wider op set, status flags and an optional iterative multiplier. It sits between an operand-issuing controller and a result consumer. Single-cycle ops complete with latency 1. MUL is multi-cycle, and all results are held under back-pressure.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64.
- MUL_EN, 1, 1 = MUL op implemented; 0 = MUL treated as illegal opcode.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand/op valid.
- in_ready  out  1  block can accept; transfer occurs when in_valid & in_ready at a clock edge.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B; for shifts only b[$clog2(WIDTH)-1:0] is used.
- in_op  in  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 SRA, 8 SLT, 9 SLTU, 10 MUL, 11-15 illegal.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts; result transfer occurs when out_valid & out_ready at a clock edge.
- out_result  out  WIDTH  result.
- out_zero  out  1  out_result == 0.
- out_neg  out  1  out_result[WIDTH-1].
- out_carry  out  1  carry/borrow/shift-out/MUL-truncation (see below).
- out_ovf  out  1  signed overflow (ADD/SUB only).
- out_illegal  out  1  opcode was illegal.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, out_valid=0, in_ready=1, out_result=0, and all flags 0.
- States:
  - IDLE: no result pending.
  - BUSY: MUL iterating.
  - DONE: result held in output register.
- in_ready = (state==IDLE) | (state==DONE & out_ready). BUSY forces in_ready=0. Inputs offered while in_ready=0 are ignored, not queued.
- Accept of a non-MUL op (legal or illegal): the result and flags are registered at the accept edge, giving state=DONE and out_valid=1 in the next cycle (latency 1).
- Accept of MUL (MUL_EN=1):
  - Enter BUSY with step counter=0 and latched operands.
  - Perform one shift-add step per cycle, building a 2*WIDTH product.
  - The step at counter==WIDTH-1 moves to DONE.
  - out_valid goes high exactly WIDTH edges after the accept edge.
- DONE:
  - Outputs are stable while out_valid & !out_ready.
  - On out_ready with no new accept: go to IDLE and drop out_valid.
  - On out_ready with a simultaneous accept: load the new op directly (non-MUL: stay DONE with the new result, giving back-to-back throughput of 1/cycle; MUL: go to BUSY with out_valid=0).
- Arithmetic is modulo 2^WIDTH.
  - ADD: carry = carry-out of unsigned sum; ovf = signed overflow.
  - SUB: a-b; carry = borrow (a<b unsigned); ovf = signed overflow.
  - AND/OR/XOR: carry=0, ovf=0.
  - SHL/SHR/SRA: shift by amount s; carry = last bit shifted out, 0 when s=0; ovf=0. SRA sign-extends.
  - SLT/SLTU: result = zero-extended 1/0 of signed/unsigned a<b; carry=0, ovf=0.
  - MUL: result = low WIDTH bits of unsigned product; carry = 1 if the high WIDTH bits are nonzero; ovf=0.
- Flags for every op: zero and neg are derived from the registered result.
- Illegal op (11-15, or 10 when MUL_EN=0): result=0, zero=1, illegal=1, and neg, carry and ovf all 0. It completes with latency 1 like any single-cycle op.
- Reset mid-operation: an rst edge in BUSY or DONE abandons the operation. The next cycle shows IDLE, out_valid=0 and in_ready=1. No partial result is ever presented.
- in_op, in_a and in_b are sampled only at the accept edge. Changes during BUSY have no effect.

Test Plan (WIDTH=8, MUL_EN=1 unless stated):
1. ADD a=0xFF, b=0x01, out_ready=1 -> one cycle later out_valid=1, result=0x00, zero=1, carry=1, ovf=0, neg=0.
2. SUB a=0x80, b=0x01 -> result=0x7F, ovf=1, carry=0, neg=0. Then SLT a=0x80, b=0x01 back-to-back -> result=0x01. Next SLTU with the same operands -> result=0x00, zero=1. in_ready stays 1 throughout.
3. MUL a=0x10, b=0x11 -> in_ready=0 for 8 cycles, out_valid rises exactly 8 edges after accept, result=0x10, carry=1. Also MUL 0x0F*0x03 -> result=0x2D, carry=0.
4. Back-pressure: ADD accepted while out_ready=0 for 3 cycles -> result/flags stable and in_ready=0. Raising out_ready together with a new XOR 0xAA^0xFF -> next cycle result=0x55 with no IDLE bubble.
5. SRA a=0x81, b=0x01 -> result=0xC0, carry=1, neg=1. SHL a=0x81, b=0x00 -> result=0x81, carry=0. Op 4'hF -> result=0, illegal=1, zero=1. With MUL_EN=0, op 10 -> illegal=1 with latency 1.
6. Assert rst for one cycle at step 4 of a MUL -> next cycle out_valid=0, in_ready=1, result=0. A subsequent ADD 0x02+0x03 -> result=0x05.
